// File: rtl/result_ascii_encoder.sv
`default_nettype none
// ============================================================================
// Module   : result_ascii_encoder
// Brief    : Signed 32-bit ALU result to ASCII decimal byte stream (UART TX).
// Revision : 1.0 - initial release
// ============================================================================

module result_ascii_encoder #(
   parameter logic [7:0] TERM_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        alu_done,
   input  logic [31:0] calc_res,
   output logic [7:0]  tx_data,
   output logic        uout_valid
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_CONV  = 3'd1;
   localparam logic [2:0] c_SIGN  = 3'd2;
   localparam logic [2:0] c_DIGIT = 3'd3;
   localparam logic [2:0] c_TERM  = 3'd4;

   localparam logic [5:0] c_CONV_STEPS = 6'd32;
   localparam logic [7:0] c_MINUS      = 8'h2D;
   localparam logic [7:0] c_ZERO       = 8'h30;

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic        r_done_q;
   logic        r_sign;
   logic [31:0] r_mag;
   logic [39:0] r_bcd;
   logic [5:0]  r_cnt;
   logic [3:0]  r_idx;
   logic [3:0]  w_idx_nxt;
   logic [7:0]  r_tx_data;
   logic        r_valid;
   logic [7:0]  w_tx_nxt;
   logic        w_valid_nxt;

   logic        w_start;
   logic [39:0] w_adj;
   logic [3:0]  w_lead;
   logic [3:0]  w_digit;

   assign w_start = alu_done & ~r_done_q;

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
   for (genvar gi = 0; gi < 10; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                          : r_bcd[gi*4 +: 4];
   end

   // Index of the most significant non-zero digit; zero value yields digit 0
   always_comb begin
      w_lead = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (r_bcd[i*4 +: 4] != 4'd0) begin
            w_lead = i[3:0];
         end
      end
   end

   always_comb begin
      w_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (w_idx_nxt == i[3:0]) begin
            w_digit = r_bcd[i*4 +: 4];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic, including the digit pointer for the byte about to go out
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         c_IDLE: begin
            if (w_start) begin
               w_state_nxt = c_CONV;
            end
         end
         c_CONV: begin
            if (r_cnt == c_CONV_STEPS) begin
               w_state_nxt = r_sign ? c_SIGN : c_DIGIT;
               w_idx_nxt   = w_lead;
            end
         end
         c_SIGN: begin
            w_state_nxt = c_DIGIT;
         end
         c_DIGIT: begin
            if (r_idx == 4'd0) begin
               w_state_nxt = c_TERM;
            end else begin
               w_idx_nxt = r_idx - 4'd1;
            end
         end
         c_TERM: begin
            w_state_nxt = c_IDLE;
         end
         default: begin
            w_state_nxt = c_IDLE;
         end
      endcase
   end

   // Output logic: byte registered on entry to each emitting state
   always_comb begin
      w_valid_nxt = 1'b0;
      w_tx_nxt    = r_tx_data;
      case (w_state_nxt)
         c_SIGN: begin
            w_valid_nxt = 1'b1;
            w_tx_nxt    = c_MINUS;
         end
         c_DIGIT: begin
            w_valid_nxt = 1'b1;
            w_tx_nxt    = c_ZERO + {4'h0, w_digit};
         end
         c_TERM: begin
            w_valid_nxt = 1'b1;
            w_tx_nxt    = TERM_CHAR;
         end
         default: begin
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         r_done_q  <= 1'b0;
         r_sign    <= 1'b0;
         r_mag     <= 32'd0;
         r_bcd     <= 40'd0;
         r_cnt     <= 6'd0;
         r_idx     <= 4'd0;
         r_tx_data <= 8'h00;
         r_valid   <= 1'b0;
      end else begin
         r_done_q  <= alu_done;
         r_idx     <= w_idx_nxt;
         r_tx_data <= w_tx_nxt;
         r_valid   <= w_valid_nxt;
         if ((r_state == c_IDLE) && w_start) begin
            r_sign <= calc_res[31];
            r_mag  <= calc_res[31] ? (~calc_res + 32'd1) : calc_res;
            r_bcd  <= 40'd0;
            r_cnt  <= 6'd0;
         end else if ((r_state == c_CONV) && (r_cnt != c_CONV_STEPS)) begin
            r_bcd <= {w_adj[38:0], r_mag[31]};
            r_mag <= {r_mag[30:0], 1'b0};
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end

   assign tx_data    = r_tx_data;
   assign uout_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_result_ascii_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_ascii_encoder
// Brief    : Scoreboard bench for result_ascii_encoder (data and byte timing).
// Revision : 1.0 - initial release
// ============================================================================

module tb_result_ascii_encoder;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        alu_done = 1'b0;
   logic [31:0] calc_res = 32'd0;
   logic [7:0]  tx_data;
   logic        uout_valid;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] b;
      int         at;
   } exp_t;

   exp_t sb[$];

   result_ascii_encoder #(.TERM_CHAR(8'h20)) u_dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .alu_done   (alu_done),
      .calc_res   (calc_res),
      .tx_data    (tx_data),
      .uout_valid (uout_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expected bytes of a conversion started on posedge c0; byte k due after edge c0+33+k
   task automatic push_expected(input logic [31:0] v, input int c0);
      longint unsigned m;
      logic [7:0]      digs[$];
      exp_t            e;
      int              k;
      m = v[31] ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
      do begin
         digs.push_front(8'h30 + 8'(m % 10));
         m = m / 10;
      end while (m != 0);
      k = 0;
      if (v[31]) begin
         e.b = 8'h2D; e.at = c0 + 33 + k; sb.push_back(e); k++;
      end
      foreach (digs[i]) begin
         e.b = digs[i]; e.at = c0 + 33 + k; sb.push_back(e); k++;
      end
      e.b = 8'h20; e.at = c0 + 33 + k; sb.push_back(e);
   endtask

   task automatic start(input logic [31:0] v, output int c0);
      @(negedge clk);
      calc_res = v;
      alu_done = 1'b1;
      c0 = cyc + 1;
      push_expected(v, c0);
   endtask

   task automatic wait_drain(input string tag);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check(tag, sb.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (uout_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(uout_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("byte", {24'd0, tx_data}, {24'd0, e.b});
            check("byte_cycle", cyc, e.at);
         end
      end
   end

   logic [31:0] vecs[$] = '{32'h0000_0000, 32'hFFFF_FFF6, 32'h8000_0000, 32'h7FFF_FFFF,
                            32'h0000_0009, 32'h0000_000A, 32'hFFFF_FFFF, 32'h3B9A_CA00};

   initial begin
      int c0;

      repeat (3) @(negedge clk);
      check("rst_valid", 32'(uout_valid), 32'd0);
      check("rst_tx", {24'd0, tx_data}, 32'd0);
      n_rst = 1'b0;

      // Held-high start: exactly one burst
      start(32'h123F_5A78, c0);
      wait_drain("drain_held");
      repeat (40) @(negedge clk);
      check("hold_tx", {24'd0, tx_data}, 32'h20);
      check("hold_valid", 32'(uout_valid), 32'd0);
      alu_done = 1'b0;

      foreach (vecs[i]) begin
         start(vecs[i], c0);
         @(negedge clk) alu_done = 1'b0;
         wait_drain("drain_vec");
      end
      for (int i = 0; i < 4; i++) begin
         start($urandom, c0);
         @(negedge clk) alu_done = 1'b0;
         wait_drain("drain_rand");
      end

      // Starts during CONV and EMIT are ignored
      start(32'h1234_5678, c0);
      @(negedge clk) alu_done = 1'b0;
      repeat (8) @(negedge clk);
      calc_res = 32'hDEAD_BEEF; alu_done = 1'b1;
      @(negedge clk) alu_done = 1'b0;
      repeat (25) @(negedge clk);
      calc_res = 32'h0000_0042; alu_done = 1'b1;
      @(negedge clk) alu_done = 1'b0;
      wait_drain("drain_ignore");
      repeat (60) @(negedge clk);

      // Start coinciding with the return-to-IDLE edge is ignored
      start(32'd5, c0);
      @(negedge clk) alu_done = 1'b0;
      repeat (34) @(negedge clk);
      calc_res = 32'd7; alu_done = 1'b1;
      repeat (60) @(negedge clk);
      check("late_start_sb", sb.size(), 0);
      alu_done = 1'b0;
      start(32'd7, c0);
      @(negedge clk) alu_done = 1'b0;
      wait_drain("drain_after_late");

      // Reset at third emitted byte aborts the stream
      start(32'hFFFF_CFC7, c0);
      @(negedge clk) alu_done = 1'b0;
      repeat (35) @(negedge clk);
      #1;
      n_rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("abort_valid", 32'(uout_valid), 32'd0);
      check("abort_tx", {24'd0, tx_data}, 32'd0);
      @(negedge clk) n_rst = 1'b0;
      repeat (40) @(negedge clk);
      start(32'd987654321, c0);
      @(negedge clk) alu_done = 1'b0;
      wait_drain("drain_post_rst");

      check("final_sb", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
